inst_fetch_ctrl: RTL and testbench

- Sits between the PC-generating IF stage and the ID stage.
- Takes the current fetch address, runs one request at a time on an SRAM-like instruction bus, and produces the IF/ID pipeline register contents: valid, pc and instruction.
- Stalls the PC while a fetch is outstanding.
- Cancels in-flight fetches on branch or exception redirects, and buffers one returned instruction while ID is stalled.

---
 rtl/inst_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: single-outstanding SRAM-like bus master feeding the IF/ID register.
// Handles redirect cancellation, a one-entry hold buffer for ID stalls, and misaligned-PC (AdEL) delivery.
module inst_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              flush,
    input  logic              id_stall,
    output logic              fetch_stall,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [INST_W-1:0] inst_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_adel
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              lat_q, lat_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [INST_W-1:0] hold_inst_q, hold_inst_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_adel_q, id_adel_d;

    logic              accept;
    logic              req_o;
    logic [ADDR_W-1:0] acc_pc;
    logic [INST_W-1:0] acc_inst;
    logic              acc_adel;
    logic [ADDR_W-1:0] cur_addr;

    // The first REQ cycle samples pc_addr live; afterwards the latched copy keeps the bus stable.
    assign cur_addr = lat_q ? req_addr_q : pc_addr;

    always_comb begin
        state_d     = state_q;
        cancel_d    = cancel_q;
        lat_d       = lat_q;
        req_addr_d  = req_addr_q;
        hold_inst_d = hold_inst_q;
        accept      = 1'b0;
        req_o       = 1'b0;
        acc_pc      = req_addr_q;
        acc_inst    = '0;
        acc_adel    = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d  = S_REQ;
                lat_d    = 1'b0;
                cancel_d = 1'b0;
            end
            S_REQ: begin
                if (!lat_q && cur_addr[1:0] != 2'b00) begin
                    acc_pc   = cur_addr;
                    acc_adel = 1'b1;
                    accept   = !flush && !id_stall;
                    lat_d    = 1'b0;
                end else begin
                    req_o      = 1'b1;
                    req_addr_d = cur_addr;
                    lat_d      = 1'b1;
                    if (flush)        cancel_d = 1'b1;
                    if (inst_addr_ok) state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) cancel_d = 1'b1;
                if (inst_data_ok) begin
                    if (cancel_q || flush) begin
                        // The outstanding response is consumed here, so the cancel is spent.
                        cancel_d = 1'b0;
                        state_d  = S_REQ;
                        lat_d    = 1'b0;
                    end else if (!id_stall) begin
                        accept   = 1'b1;
                        acc_inst = inst_rdata;
                        state_d  = S_REQ;
                        lat_d    = 1'b0;
                    end else begin
                        hold_inst_d = inst_rdata;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_REQ;
                    lat_d   = 1'b0;
                end else if (!id_stall) begin
                    accept   = 1'b1;
                    acc_inst = hold_inst_q;
                    state_d  = S_REQ;
                    lat_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_adel_d  = id_adel_q;
        if (flush) begin
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
        end else if (accept) begin
            id_valid_d = 1'b1;
            id_pc_d    = acc_pc;
            id_inst_d  = acc_inst;
            id_adel_d  = acc_adel;
        end else if (!id_stall) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cancel_q    <= 1'b0;
            lat_q       <= 1'b0;
            req_addr_q  <= '0;
            hold_inst_q <= '0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= RESET_PC;
            id_inst_q   <= '0;
            id_adel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cancel_q    <= cancel_d;
            lat_q       <= lat_d;
            req_addr_q  <= req_addr_d;
            hold_inst_q <= hold_inst_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_adel_q   <= id_adel_d;
        end
    end

    assign inst_req    = req_o && !rst;
    assign inst_addr   = (req_o && !rst) ? cur_addr : '0;
    assign fetch_stall = !(accept && !rst);
    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_adel     = id_adel_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: IF-stage PC model, zero-wait bus model with gating, and a delivery scoreboard.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk, rst, flush, id_stall;
    logic [31:0] pc_addr, tgt;
    logic        fetch_stall, inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata, id_pc, id_inst;
    logic        id_valid, id_adel;

    logic        pending, dok_en, ovr_en, acc_rec;
    logic [31:0] ovr, lat_addr;
    int          grants_given, grants_used, ndel, n_chk, n_fail;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;
    exp_t sb[$];

    inst_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .flush(flush), .id_stall(id_stall),
        .fetch_stall(fetch_stall), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_adel(id_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3c08_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        exp_t e;
        e.pc = pc; e.inst = inst; e.adel = adel;
        sb.push_back(e);
    endtask

    // Bus grants a request only while the bench has handed out credits.
    assign inst_addr_ok = inst_req && (grants_used != grants_given);
    assign inst_data_ok = pending && dok_en;
    assign inst_rdata   = ovr_en ? ovr : mem(lat_addr);

    always @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            if (inst_data_ok) pending <= 1'b0;
            if (inst_req && inst_addr_ok) begin
                pending     <= 1'b1;
                lat_addr    <= inst_addr;
                grants_used <= grants_used + 1;
            end
        end
    end

    // IF stage: redirect always wins, otherwise advance only on an accept cycle.
    always @(posedge clk) begin
        if (rst)               pc_addr <= RPC;
        else if (flush)        pc_addr <= tgt;
        else if (!fetch_stall) pc_addr <= pc_addr + 32'd4;
    end

    always @(posedge clk) begin
        acc_rec <= !fetch_stall;
        if (!fetch_stall) ndel <= ndel + 1;
    end

    always @(negedge clk) begin
        if (acc_rec) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_valid", id_valid, 1);
                chk("sb_pc",    id_pc,    e.pc);
                chk("sb_inst",  id_inst,  e.inst);
                chk("sb_adel",  id_adel,  e.adel);
            end
        end
    end

    task automatic chk_reset(input string p);
        chk({p, "_req"},   inst_req,    0);
        chk({p, "_addr"},  inst_addr,   0);
        chk({p, "_valid"}, id_valid,    0);
        chk({p, "_pc"},    id_pc,       RPC);
        chk({p, "_inst"},  id_inst,     0);
        chk({p, "_adel"},  id_adel,     0);
        chk({p, "_fs"},    fetch_stall, 1);
    endtask

    task automatic wait_del(input int target);
        int n = 0;
        while (ndel < target && n < 30) begin @(negedge clk); n++; end
        chk("timeout_del", ndel >= target, 1);
    endtask

    task automatic wait_dok();
        int n = 0;
        do begin @(negedge clk); n++; end while (!inst_data_ok && n < 30);
        chk("timeout_dok", inst_data_ok, 1);
    endtask

    task automatic wait_pend();
        int n = 0;
        do begin @(negedge clk); n++; end while (!pending && n < 30);
        chk("timeout_pend", pending, 1);
    endtask

    task automatic wait_acc();
        int n = 0;
        do begin @(negedge clk); n++; end while (fetch_stall && n < 30);
        chk("timeout_acc", fetch_stall, 0);
    endtask

    initial begin
        int b, g;
        rst = 1; flush = 0; tgt = '0; id_stall = 0; dok_en = 1; ovr_en = 0; ovr = '0;
        grants_given = 0; grants_used = 0; ndel = 0; n_chk = 0; n_fail = 0;
        acc_rec = 0; pending = 0; lat_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1 rst = 0;

        // Zero-wait back-to-back fetches
        b = ndel;
        push(RPC, mem(RPC), 0);
        push(RPC + 4, mem(RPC + 4), 0);
        grants_given += 2;
        wait_del(b + 2);
        repeat (3) @(negedge clk);
        chk("t1_acc_cnt", ndel, b + 2);

        // Data returns while ID stalls for three cycles
        id_stall = 1; ovr = 32'h2408_0001; ovr_en = 1;
        push(RPC + 8, 32'h2408_0001, 0);
        grants_given += 1;
        wait_dok();
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_fs",   fetch_stall, 1);
            chk("t2_stall_inst", id_inst,     mem(RPC + 4));
            chk("t2_stall_pc",   id_pc,       RPC + 4);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1 id_stall = 0;
        @(negedge clk);
        chk("t2_rel_fs", fetch_stall, 0);
        ovr_en = 0;
        @(negedge clk);
        chk("t2_fs_once", fetch_stall, 1);

        // Flush in WAIT discards the returning word
        dok_en = 0;
        grants_given += 1;
        wait_pend();
        flush = 1; tgt = 32'h8000_0180;
        @(posedge clk); #1 flush = 0; ovr = 32'hDEAD_BEEF; ovr_en = 1; dok_en = 1; b = ndel;
        @(negedge clk);
        chk("t3_drop_fs", fetch_stall, 1);
        @(posedge clk); #1 ovr_en = 0;
        @(negedge clk);
        chk("t3_valid",   id_valid,  0);
        chk("t3_cnt",     ndel,      b);
        chk("t3_req",     inst_req,  1);
        chk("t3_newaddr", inst_addr, 32'h8000_0180);
        push(32'h8000_0180, mem(32'h8000_0180), 0);
        grants_given += 1;
        wait_del(b + 1);

        // Flush in the same cycle as an accept
        b = ndel;
        grants_given += 1;
        wait_dok();
        flush = 1; tgt = 32'h8000_0200;
        #1 chk("t4_flush_fs", fetch_stall, 1);
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("t4_valid", id_valid, 0);
        chk("t4_cnt",   ndel,     b);

        // Redirect to a misaligned PC while a request is still pending on the bus
        flush = 1; tgt = RPC + 2;
        @(posedge clk); #1 flush = 0;
        push(RPC + 2, 32'h0, 1);
        b = ndel; g = grants_used;
        grants_given += 1;
        wait_acc();
        chk("t5_noreq",    inst_req,    0);
        chk("t5_staleadr", lat_addr,    32'h8000_0200);
        chk("t5_grants",   grants_used, g + 1);
        @(negedge clk);
        flush = 1; tgt = RPC + 32'h10;
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("t5_cnt", ndel, b + 1);

        // Reset while a fetch is in WAIT, then a clean refetch
        dok_en = 0;
        grants_given += 1;
        wait_pend();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("t6");
        @(posedge clk); #1 rst = 0; dok_en = 1;
        b = ndel;
        push(RPC, mem(RPC), 0);
        grants_given += 1;
        wait_del(b + 1);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
